rhs_spi_slave_model: RTL and testbench
======================================

Name: rhs_spi_slave_model

Overview:
- Parametrised behavioural/synthesizable model of an RHS-class stimulation/recording amplifier SPI slave, used as the device under the host SPI master in simulation and FPGA loopback builds.
- Decodes 32-bit CONVERT/READ/WRITE/CLEAR frames and holds a small register file.
- Generates per-channel deterministic sample patterns and returns each reply two frames after its command, matching device pipelining.
- Runs on a system clock with oversampled SCLK/CS/MOSI; replaces the SCLK-clocked fixed-pattern slave.

Parameters:
- NUM_CHANNELS, 16, number of addressable amplifier channels (1..64).
- STARTING_SEED, 0, 16-bit offset added to every generated sample.
- PATTERN_MODE, 0, 0 = static (seed+channel), 1 = per-channel incrementing counter.
- REG_DEPTH, 16, number of 16-bit writable registers (addresses 0..REG_DEPTH-1).
- CHIP_ID, 16'h0020, value returned by READ of address 255.
- SYNC_STAGES, 2, synchroniser depth on sclk/cs/mosi (>=2).

Ports:
- clk, input, 1, system clock; must run at >=8x SCLK.
- rstn, input, 1, reset, asynchronous, active-low.
- sclk, input, 1, SPI clock from master, idle low.
- cs, input, 1, chip select, active-low frame (high = idle).
- mosi, input, 1, serial data from master, MSB first.
- miso, output, 1, serial data to master, MSB first.
- frame_done, output, 1, one-clk pulse when a complete 32-bit frame is accepted.
- last_cmd, output, 32, last complete frame received; valid from the frame_done pulse.
- frame_count, output, 16, count of completed frames; wraps at 16'hFFFF->0.

Behaviour:
- Reset: miso=0, frame_done=0, last_cmd=0, frame_count=0, register file=0, pattern counters=0, both reply-pipeline slots=32'h0, bit counter=0.
- sclk, cs and mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronised signals.
- States: IDLE (cs high) -> SHIFT (on cs fall) -> EXEC (after 32nd rising edge) -> WAIT_CS (until cs rises) -> IDLE.
- SHIFT:
  - mosi is sampled on each synchronised sclk rise.
  - On cs fall, miso = reply_slot0[31] within SYNC_STAGES+1 clks.
  - After each sclk fall, miso advances one bit toward bit 0.
- EXEC:
  - lasts one clk.
  - Decodes the frame, computes its reply and pushes it into the pipeline: slot0<=slot1, slot1<=new reply.
  - Pulses frame_done, updates last_cmd and increments frame_count.
- Reply timing: the reply to frame N is shifted out during frame N+2. After reset, the first two frames shift out 32'h0.
- Early abort: cs rises before 32 rising edges. Frame discarded, no decode, pipeline unchanged, frame_count unchanged, returns to IDLE.
- Extra edges: sclk edges beyond 32 in one cs-low window are ignored; miso holds 0 after bit 0.
- miso=0 whenever cs is high.
- Decode on bits [31:30]:
  - 00 CONVERT, channel = [21:16].
    - channel < NUM_CHANNELS: ac = STARTING_SEED + channel + cnt[channel] (mod 2^16); reply = {ac, 6'b0, ~ac[9:0]}.
    - cnt[channel] increments (wrapping) after the CONVERT only when PATTERN_MODE=1; in mode 0 cnt stays 0.
    - channel >= NUM_CHANNELS: reply = 0 and no counter change.
  - 10 WRITE, addr = [23:16], data = [15:0].
    - addr < REG_DEPTH: register written; reply = {16'hFFFF, data}.
    - Otherwise the write is dropped; reply is still {16'hFFFF, data}.
  - 11 READ, addr = [23:16].
    - reply = {16'h0000, reg[addr]} if addr < REG_DEPTH.
    - addr 255: {16'h0000, CHIP_ID}.
    - Else 0.
  - 01:
    - CLEAR when [29:24]=6'b101010: all pattern counters zeroed; reply = 0. Registers are untouched.
    - Other 01 codes: reply = 0.
- Write then read in the next frame returns the new value, because writes commit in EXEC.
- Reset mid-frame: immediate return to IDLE with all reset values. A partially shifted frame is lost.

Decomposition:
- Package rhs_spi_pkg:
  - opcode constants: OP_CONVERT=2'b00, OP_WRITE=2'b10, OP_READ=2'b11, OP_MISC=2'b01.
  - CLEAR_KEY=6'b101010, FRAME_BITS=32, WRITE_ACK=16'hFFFF, CHIP_ID_ADDR=8'd255.
  - state enum.
- Sub-module rhs_spi_shifter: synchronisers, edge detect, bit counter, 32-bit shift-in/shift-out, abort detection. Outputs frame_valid, rx_word and takes tx_word.
- Top holds decode, register file, pattern counters and reply pipeline.

Test Plan:
- Reset, then CONVERT ch3, CONVERT ch4, CONVERT ch5 (SEED=0, mode 0) -> miso frames 0, 0, 32'h0003_03FC; frame_count=3.
- Mode 1, SEED=16'h0100: CONVERT ch2 x3, then 2 dummy READ 255 -> replies 32'h0102_02FD, 32'h0103_02FC, 32'h0104_02FB.
- WRITE addr5 data 16'hBEEF, READ 5, READ 255, READ 5, READ 20 -> replies FFFF_BEEF, 0000_BEEF, 0000_0020, then 0000_BEEF, 0 (the last two appear in padding frames).
- cs released after 17 sclk edges mid-WRITE addr1 16'h1234, then READ 1 x3 -> frame_done not pulsed for the aborted frame; register 1 reads 0; frame_count counts 3.
- CONVERT ch20 (NUM_CHANNELS=16) -> reply 0 two frames later. CLEAR after mode-1 converts -> next CONVERT ch2 returns SEED+2.
- rstn low during bit 10 of a frame -> miso=0 immediately; the next full frames return 0, 0 (pipeline flushed).

Source files
------------

// File: rtl/rhs_spi_pkg.sv
// Shared constants, FSM state type and reply formatting for the RHS SPI
// slave model.
package rhs_spi_pkg;

    localparam logic [1:0]  OP_CONVERT   = 2'b00;
    localparam logic [1:0]  OP_WRITE     = 2'b10;
    localparam logic [1:0]  OP_READ      = 2'b11;
    localparam logic [1:0]  OP_MISC      = 2'b01;

    localparam logic [5:0]  CLEAR_KEY    = 6'b101010;
    localparam int          FRAME_BITS   = 32;
    localparam logic [15:0] WRITE_ACK    = 16'hFFFF;
    localparam logic [7:0]  CHIP_ID_ADDR = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_EXEC,
        ST_WAIT_CS
    } spi_state_t;

    // A CONVERT reply carries the sample in the upper half and the
    // inverted low ten bits in the lower half, so the master can spot
    // bit slips in either half of the frame.
    function automatic logic [31:0] convert_reply(input logic [15:0] ac);
        return {ac, 6'b000000, ~ac[9:0]};
    endfunction

endpackage

// File: rtl/rhs_spi_shifter.sv
// Oversampled SPI front end: synchronises sclk/cs/mosi onto clk, tracks the
// frame with a small FSM, shifts the command in on sclk rises and the reply
// out on sclk falls. frame_valid is high for exactly one clk per complete
// 32-bit frame; aborted frames never raise it.
module rhs_spi_shifter
    import rhs_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    input  logic [31:0] tx_word,
    output logic        miso,
    output logic        frame_valid,
    output logic [31:0] rx_word
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;

    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_fall;
    logic                   last_bit;

    spi_state_t             state;
    spi_state_t             state_nxt;

    logic [5:0]             bit_cnt;
    logic [31:0]            rx_sr;
    logic [31:0]            tx_sr;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign last_bit  = (bit_cnt == 6'(FRAME_BITS - 1));

    // Synchronise the SPI pins and keep one delayed copy for edge detection;
    // cs resets high so an idle bus looks idle straight out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencing: a cs rise before the 32nd sclk rise abandons the
    // frame without ever passing through EXEC.
    always_comb begin
        state_nxt   = state;
        frame_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_s) begin
                    state_nxt = ST_IDLE;
                end else if (sclk_rise && last_bit) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                frame_valid = 1'b1;
                state_nxt   = ST_WAIT_CS;
            end
            ST_WAIT_CS: begin
                if (cs_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift registers and bit counter. The reply word is captured at cs
    // fall; zero fill on the way out keeps miso low after bit 0 no matter
    // how many extra sclk falls arrive.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
        end else if (state == ST_IDLE) begin
            if (cs_fall) begin
                bit_cnt <= '0;
                rx_sr   <= '0;
                tx_sr   <= tx_word;
            end
        end else begin
            if (state == ST_SHIFT && sclk_rise && !cs_s) begin
                rx_sr   <= {rx_sr[30:0], mosi_s};
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (sclk_fall) begin
                tx_sr <= {tx_sr[30:0], 1'b0};
            end
        end
    end

    // The raw cs gate forces miso low the moment the master deselects,
    // without waiting for the synchroniser.
    assign miso    = tx_sr[31] & ~cs & (state != ST_IDLE);
    assign rx_word = rx_sr;

endmodule

// File: rtl/rhs_spi_slave_model.sv
// RHS-class amplifier SPI slave model: decodes CONVERT/READ/WRITE/CLEAR
// frames, holds a small register file and per-channel pattern counters, and
// returns each reply two frames after its command.
module rhs_spi_slave_model
    import rhs_spi_pkg::*;
#(
    parameter int          NUM_CHANNELS  = 16,
    parameter logic [15:0] STARTING_SEED = 16'h0000,
    parameter int          PATTERN_MODE  = 0,
    parameter int          REG_DEPTH     = 16,
    parameter logic [15:0] CHIP_ID       = 16'h0020,
    parameter int          SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        frame_done,
    output logic [31:0] last_cmd,
    output logic [15:0] frame_count
);

    logic        frame_valid;
    logic [31:0] rx_word;
    logic [31:0] reply_slot0;
    logic [31:0] reply_slot1;
    logic [31:0] reply_new;

    logic [15:0] regs [REG_DEPTH];
    logic [15:0] cnt  [NUM_CHANNELS];

    logic [1:0]  opcode;
    logic [5:0]  ch;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        is_clear;
    logic        ch_hit;
    logic [15:0] ch_cnt;
    logic        reg_hit;
    logic [15:0] reg_val;

    assign opcode   = rx_word[31:30];
    assign ch       = rx_word[21:16];
    assign addr     = rx_word[23:16];
    assign wdata    = rx_word[15:0];
    assign is_clear = (opcode == OP_MISC) && (rx_word[29:24] == CLEAR_KEY);

    rhs_spi_shifter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shifter (
        .clk         (clk),
        .rstn        (rstn),
        .sclk        (sclk),
        .cs          (cs),
        .mosi        (mosi),
        .tx_word     (reply_slot0),
        .miso        (miso),
        .frame_valid (frame_valid),
        .rx_word     (rx_word)
    );

    // Look up the addressed channel counter and register; the hit flags
    // double as the range checks against NUM_CHANNELS and REG_DEPTH.
    always_comb begin
        ch_hit  = 1'b0;
        ch_cnt  = '0;
        reg_hit = 1'b0;
        reg_val = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (ch == 6'(i)) begin
                ch_hit = 1'b1;
                ch_cnt = cnt[i];
            end
        end
        for (int i = 0; i < REG_DEPTH; i++) begin
            if (addr == 8'(i)) begin
                reg_hit = 1'b1;
                reg_val = regs[i];
            end
        end
    end

    // Build the reply for the frame currently sitting in rx_word.
    always_comb begin
        reply_new = '0;
        case (opcode)
            OP_CONVERT: begin
                if (ch_hit) begin
                    reply_new = convert_reply(STARTING_SEED + {10'b0, ch} + ch_cnt);
                end
            end
            OP_WRITE: begin
                reply_new = {WRITE_ACK, wdata};
            end
            OP_READ: begin
                if (reg_hit) begin
                    reply_new = {16'h0000, reg_val};
                end else if (addr == CHIP_ID_ADDR) begin
                    reply_new = {16'h0000, CHIP_ID};
                end
            end
            default: begin
                reply_new = '0;
            end
        endcase
    end

    // Register file: writes commit in EXEC so a READ in the very next
    // frame already sees the new value. Out-of-range writes are dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (frame_valid && opcode == OP_WRITE) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                if (addr == 8'(i)) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Pattern counters: advance per CONVERT only in incrementing mode,
    // and are all zeroed by CLEAR.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else if (frame_valid) begin
            if (is_clear) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    cnt[i] <= '0;
                end
            end else if (PATTERN_MODE == 1 && opcode == OP_CONVERT) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (ch == 6'(i)) begin
                        cnt[i] <= cnt[i] + 16'd1;
                    end
                end
            end
        end
    end

    // Two-deep reply pipeline plus frame status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reply_slot0 <= '0;
            reply_slot1 <= '0;
            frame_done  <= 1'b0;
            last_cmd    <= '0;
            frame_count <= '0;
        end else begin
            frame_done <= frame_valid;
            if (frame_valid) begin
                reply_slot0 <= reply_slot1;
                reply_slot1 <= reply_new;
                last_cmd    <= rx_word;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rhs_spi_slave_model.sv
// Scoreboard bench for rhs_spi_slave_model: two instances (static pattern,
// seed 0; incrementing pattern, seed 0x0100) share sclk/mosi with separate
// chip selects. Each complete frame pushes its expected last_cmd, miso word
// and frame_count; a monitor pops and compares on every frame_done.
`timescale 1ns/1ps
module tb_rhs_spi_slave_model;

    localparam int HALF = 5;

    typedef struct packed {
        logic [31:0] cmd;
        logic [31:0] miso;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sclk;
    logic        mosi;
    logic [1:0]  cs;
    logic        miso0, miso1;
    logic        fd0, fd1;
    logic [31:0] lc0, lc1;
    logic [15:0] fc0, fc1;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] pipe0 [2];
    logic [31:0] pipe1 [2];
    logic [15:0] bcnt  [2];
    logic [31:0] seen  [2];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    rhs_spi_slave_model #(
        .NUM_CHANNELS(16), .STARTING_SEED(16'h0000), .PATTERN_MODE(0),
        .REG_DEPTH(16), .CHIP_ID(16'h0020), .SYNC_STAGES(2)
    ) dut0 (
        .clk(clk), .rstn(rstn), .sclk(sclk), .cs(cs[0]), .mosi(mosi),
        .miso(miso0), .frame_done(fd0), .last_cmd(lc0), .frame_count(fc0)
    );

    rhs_spi_slave_model #(
        .NUM_CHANNELS(16), .STARTING_SEED(16'h0100), .PATTERN_MODE(1),
        .REG_DEPTH(16), .CHIP_ID(16'h0020), .SYNC_STAGES(3)
    ) dut1 (
        .clk(clk), .rstn(rstn), .sclk(sclk), .cs(cs[1]), .mosi(mosi),
        .miso(miso1), .frame_done(fd1), .last_cmd(lc1), .frame_count(fc1)
    );

    function automatic logic [31:0] conv(input int c);
        return {2'b00, 8'h00, 6'(c), 16'h0000};
    endfunction
    function automatic logic [31:0] wr(input int a, input logic [15:0] d);
        return {2'b10, 6'b000000, 8'(a), d};
    endfunction
    function automatic logic [31:0] rd(input int a);
        return {2'b11, 6'b000000, 8'(a), 16'h0000};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic pop_check(input int d, input logic [31:0] lc, input logic [15:0] fc);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_frame_done dut%0d: last_cmd %h, no frame expected", d, lc);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("last_cmd dut%0d", d), lc, e.cmd);
        check($sformatf("miso_word dut%0d cmd %h", d, e.cmd), seen[d], e.miso);
        check($sformatf("frame_count dut%0d", d), {16'h0, fc}, {16'h0, e.cnt});
    endtask

    // Monitor: compare against the scoreboard whenever a DUT completes a frame.
    always @(negedge clk) begin
        if (fd0 === 1'b1) pop_check(0, lc0, fc0);
        if (fd1 === 1'b1) pop_check(1, lc1, fc1);
    end

    // Drive one frame on DUT d. When push is set, the expected response is
    // queued first: the miso word is the reply two commands back.
    task automatic frame(input int d, input logic [31:0] cmd, input int nbits,
                         input logic [31:0] rep, input bit push);
        exp_t e;
        logic mb;
        logic extra;
        extra = 1'b0;
        if (push) begin
            bcnt[d] = bcnt[d] + 16'd1;
            e.cmd   = cmd;
            e.miso  = pipe0[d];
            e.cnt   = bcnt[d];
            pipe0[d] = pipe1[d];
            pipe1[d] = rep;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        seen[d] = '0;
        @(negedge clk);
        cs[d] = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 32) ? cmd[31-i] : 1'b0;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            #1;
            mb = (d == 0) ? miso0 : miso1;
            if (i < 32) seen[d] = {seen[d][30:0], mb};
            else        extra = extra | mb;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
        cs[d] = 1'b1;
        mosi  = 1'b0;
        repeat (8) @(negedge clk);
        if (nbits > 32) check($sformatf("miso_after_bit0 dut%0d", d), {31'b0, extra}, 32'h0);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pipe0[d] = '0;
            pipe1[d] = '0;
            bcnt[d]  = '0;
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        cs   = 2'b11;
        sclk = 1'b0;
        mosi = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset miso0", {31'b0, miso0}, 32'h0);
        check("reset miso1", {31'b0, miso1}, 32'h0);
        check("reset frame_done", {31'b0, fd0}, 32'h0);
        check("reset frame_count", {16'h0, fc0}, 32'h0);
        check("reset last_cmd", lc0, 32'h0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Static pattern, seed 0: first two frames return 0.
        frame(0, conv(3), 32, 32'h0003_03FC, 1);
        frame(0, conv(4), 32, 32'h0004_03FB, 1);
        frame(0, conv(5), 32, 32'h0005_03FA, 1);

        // Write/read back, chip id, out-of-range read.
        frame(0, wr(5, 16'hBEEF), 32, 32'hFFFF_BEEF, 1);
        frame(0, rd(5),   32, 32'h0000_BEEF, 1);
        frame(0, rd(255), 32, 32'h0000_0020, 1);
        frame(0, rd(5),   32, 32'h0000_BEEF, 1);
        frame(0, rd(20),  32, 32'h0000_0000, 1);
        frame(0, rd(255), 32, 32'h0000_0020, 1);
        frame(0, rd(255), 32, 32'h0000_0020, 1);

        // Aborted WRITE after 17 edges: no frame_done, register 1 untouched.
        frame(0, wr(1, 16'h1234), 17, 32'h0, 0);
        frame(0, rd(1), 32, 32'h0000_0000, 1);
        frame(0, rd(1), 32, 32'h0000_0000, 1);
        frame(0, rd(1), 32, 32'h0000_0000, 1);

        // Out-of-range channel, static mode repeat, dropped write, misc code,
        // extra sclk edges.
        frame(0, conv(20), 32, 32'h0000_0000, 1);
        frame(0, conv(3),  32, 32'h0003_03FC, 1);
        frame(0, wr(16, 16'h0055), 32, 32'hFFFF_0055, 1);
        frame(0, rd(16), 32, 32'h0000_0000, 1);
        frame(0, 32'h4000_0000, 32, 32'h0000_0000, 1);
        frame(0, conv(4), 36, 32'h0004_03FB, 1);
        frame(0, rd(255), 32, 32'h0000_0020, 1);
        frame(0, rd(255), 32, 32'h0000_0020, 1);

        // Incrementing pattern, seed 0x0100, then CLEAR.
        frame(1, conv(2), 32, 32'h0102_02FD, 1);
        frame(1, conv(2), 32, 32'h0103_02FC, 1);
        frame(1, conv(2), 32, 32'h0104_02FB, 1);
        frame(1, 32'h6A00_0000, 32, 32'h0000_0000, 1);
        frame(1, conv(2), 32, 32'h0102_02FD, 1);
        frame(1, conv(5), 32, 32'h0105_02FA, 1);
        frame(1, conv(2), 32, 32'h0103_02FC, 1);
        frame(1, conv(20), 32, 32'h0000_0000, 1);
        frame(1, rd(255), 32, 32'h0000_0020, 1);
        frame(1, rd(255), 32, 32'h0000_0020, 1);

        // Reset during bit 10 of a frame that is shifting out FFFF_FFFF.
        frame(0, wr(5, 16'hFFFF), 32, 32'hFFFF_FFFF, 1);
        frame(0, rd(255), 32, 32'h0000_0020, 1);
        repeat (4) @(negedge clk);
        cs[0] = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            mosi = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            if (i < 9) begin
                repeat (HALF) @(negedge clk);
                sclk = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        #1;
        check("miso before reset", {31'b0, miso0}, 32'h1);
        rstn = 1'b0;
        #1;
        check("miso in reset", {31'b0, miso0}, 32'h0);
        check("frame_count in reset", {16'h0, fc0}, 32'h0);
        check("last_cmd in reset", lc0, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        sclk  = 1'b0;
        mosi  = 1'b0;
        cs[0] = 1'b1;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Pipeline and registers flushed by reset.
        frame(0, rd(255), 32, 32'h0000_0020, 1);
        frame(0, rd(5),   32, 32'h0000_0000, 1);
        frame(0, conv(3), 32, 32'h0003_03FC, 1);
        frame(0, rd(255), 32, 32'h0000_0020, 1);
        frame(0, rd(255), 32, 32'h0000_0020, 1);

        repeat (20) @(negedge clk);
        check("dut0 frames outstanding", 32'(q0.size()), 32'h0);
        check("dut1 frames outstanding", 32'(q1.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
